// File: rtl/axi_mdma_sched.sv
// axi_mdma_sched
//   Multi-channel command scheduler in front of a single axi_mdma engine.
//   Each channel posts one (src, dst, bytes) command. The scheduler splits
//   it into chunks of at most CHUNK_BYTES, issues them downstream one at a
//   time, and interleaves active channels at chunk granularity in
//   round-robin order. When a command completes or a chunk reports an
//   error, the channel gets one report with the byte count done and the
//   first nonzero chunk status.
//
// Ports
//   aclk, areset                  clock, synchronous active-high reset
//   ch_cmd_src_addr/dst_addr      per-channel addresses, channel i in slice i
//   ch_cmd_bytes                  per-channel transfer length
//   ch_cmd_valid/ch_cmd_ready     per-channel command handshake
//   ch_rpt_bytes/ch_rpt_status    per-channel completion report
//   ch_rpt_valid/ch_rpt_ready     per-channel report handshake
//   cmd_src_addr/dst_addr/bytes   downstream chunk command
//   cmd_valid/cmd_ready           downstream command handshake
//   rpt_bytes/rpt_status          downstream chunk report (length unused)
//   rpt_valid/rpt_ready           downstream report handshake
//
// state  | meaning
// IDLE   | arbitrate among active channels without a pending report
// ISSUE  | chunk command presented downstream, waiting for cmd_ready
// WAIT   | chunk outstanding, waiting for its downstream report
module axi_mdma_sched #(
  parameter int CHANNELS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int LENGTH_BITS  = 16,
  parameter int CHUNK_BYTES  = 1024
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [CHANNELS*ADDRESS_BITS-1:0] ch_cmd_src_addr,
  input  logic [CHANNELS*ADDRESS_BITS-1:0] ch_cmd_dst_addr,
  input  logic [CHANNELS*LENGTH_BITS-1:0]  ch_cmd_bytes,
  input  logic [CHANNELS-1:0]              ch_cmd_valid,
  output logic [CHANNELS-1:0]              ch_cmd_ready,
  output logic [CHANNELS*LENGTH_BITS-1:0]  ch_rpt_bytes,
  output logic [CHANNELS*2-1:0]            ch_rpt_status,
  output logic [CHANNELS-1:0]              ch_rpt_valid,
  input  logic [CHANNELS-1:0]              ch_rpt_ready,
  output logic [ADDRESS_BITS-1:0]          cmd_src_addr,
  output logic [ADDRESS_BITS-1:0]          cmd_dst_addr,
  output logic [LENGTH_BITS-1:0]           cmd_bytes,
  output logic                             cmd_valid,
  input  logic                             cmd_ready,
  input  logic [LENGTH_BITS-1:0]           rpt_bytes,
  input  logic [1:0]                       rpt_status,
  input  logic                             rpt_valid,
  output logic                             rpt_ready
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [LENGTH_BITS-1:0] CHUNK_LEN = LENGTH_BITS'(CHUNK_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [ADDRESS_BITS-1:0] ctx_src    [CHANNELS];
  logic [ADDRESS_BITS-1:0] ctx_dst    [CHANNELS];
  logic [LENGTH_BITS-1:0]  ctx_rem    [CHANNELS];
  logic [LENGTH_BITS-1:0]  ctx_done   [CHANNELS];
  logic [1:0]              ctx_status [CHANNELS];
  logic [CHANNELS-1:0]     active_q;
  logic [CHANNELS-1:0]     pend_q;

  logic [CH_W-1:0]         last_q;
  logic [CH_W-1:0]         sel_q;
  logic [ADDRESS_BITS-1:0] cmd_src_q;
  logic [ADDRESS_BITS-1:0] cmd_dst_q;
  logic [LENGTH_BITS-1:0]  cmd_len_q;

  logic [CHANNELS-1:0]     eligible;
  logic                    pick_found;
  logic [CH_W-1:0]         pick_idx;
  logic [CH_W-1:0]         cand;
  logic [LENGTH_BITS-1:0]  pick_rem;
  logic [LENGTH_BITS-1:0]  pick_len;

  // The downstream report length is redundant with the chunk length we issued.
  logic unused_rpt_bytes;
  assign unused_rpt_bytes = ^rpt_bytes;

  assign eligible = active_q & ~pend_q;

  // Round-robin search starting just after the last channel served.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = CH_W'((int'(last_q) + k) % CHANNELS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign pick_rem = ctx_rem[pick_idx];
  assign pick_len = (pick_rem > CHUNK_LEN) ? CHUNK_LEN : pick_rem;

  always_comb begin
    state_d      = state_q;
    cmd_valid    = 1'b0;
    rpt_ready    = 1'b0;
    ch_cmd_ready = '0;
    ch_rpt_valid = '0;
    case (state_q)
      ST_IDLE:  if (pick_found) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_ready)  state_d = ST_WAIT;
      ST_WAIT:  if (rpt_valid)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Handshake outputs are forced low while reset is asserted, before the
    // registers have had a chance to clear.
    if (!areset) begin
      cmd_valid    = (state_q == ST_ISSUE);
      rpt_ready    = (state_q == ST_WAIT);
      ch_cmd_ready = ~(active_q | pend_q);
      ch_rpt_valid = pend_q;
    end
  end

  always_comb begin
    ch_rpt_bytes  = '0;
    ch_rpt_status = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_rpt_bytes[i*LENGTH_BITS +: LENGTH_BITS] = ctx_done[i];
      ch_rpt_status[i*2 +: 2]                    = ctx_status[i];
    end
  end

  assign cmd_src_addr = cmd_src_q;
  assign cmd_dst_addr = cmd_dst_q;
  assign cmd_bytes    = cmd_len_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      last_q    <= CH_W'(CHANNELS - 1);
      sel_q     <= '0;
      cmd_src_q <= '0;
      cmd_dst_q <= '0;
      cmd_len_q <= '0;
      active_q  <= '0;
      pend_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ctx_src[i]    <= '0;
        ctx_dst[i]    <= '0;
        ctx_rem[i]    <= '0;
        ctx_done[i]   <= '0;
        ctx_status[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE && pick_found) begin
        sel_q     <= pick_idx;
        cmd_src_q <= ctx_src[pick_idx];
        cmd_dst_q <= ctx_dst[pick_idx];
        cmd_len_q <= pick_len;
      end

      // A channel accepting a command is never the one being served, and a
      // channel with a pending report cannot accept, so these never collide.
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_cmd_valid[i] && ch_cmd_ready[i]) begin
          ctx_src[i]    <= ch_cmd_src_addr[i*ADDRESS_BITS +: ADDRESS_BITS];
          ctx_dst[i]    <= ch_cmd_dst_addr[i*ADDRESS_BITS +: ADDRESS_BITS];
          ctx_rem[i]    <= ch_cmd_bytes[i*LENGTH_BITS +: LENGTH_BITS];
          ctx_done[i]   <= '0;
          ctx_status[i] <= '0;
          if (ch_cmd_bytes[i*LENGTH_BITS +: LENGTH_BITS] == '0) begin
            pend_q[i] <= 1'b1;
          end else begin
            active_q[i] <= 1'b1;
          end
        end
        if (ch_rpt_valid[i] && ch_rpt_ready[i]) begin
          pend_q[i] <= 1'b0;
        end
      end

      if (state_q == ST_WAIT && rpt_valid) begin
        ctx_src[sel_q]  <= ctx_src[sel_q] + ADDRESS_BITS'(cmd_len_q);
        ctx_dst[sel_q]  <= ctx_dst[sel_q] + ADDRESS_BITS'(cmd_len_q);
        ctx_rem[sel_q]  <= ctx_rem[sel_q] - cmd_len_q;
        ctx_done[sel_q] <= ctx_done[sel_q] + cmd_len_q;
        if (ctx_status[sel_q] == 2'd0) begin
          ctx_status[sel_q] <= rpt_status;
        end
        // An error status ends the transfer early.
        if (ctx_rem[sel_q] == cmd_len_q || rpt_status != 2'd0) begin
          active_q[sel_q] <= 1'b0;
          pend_q[sel_q]   <= 1'b1;
        end
        last_q <= sel_q;
      end
    end
  end

endmodule
